// File: rtl/pifo_calendar_pkg.sv
// pifo_calendar_pkg: element layout constants and arbiter FSM encoding
// shared by the PIFO calendar front end.
package pifo_calendar_pkg;

    localparam int PIFO_VALID_BIT  = 31;
    localparam int PIFO_RANK_MSB   = 30;
    localparam int PIFO_RANK_LSB   = 12;
    localparam int PIFO_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        st_run   = 2'd0,
        st_drain = 2'd1,
        st_hold  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pifo_calendar_cmd_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting at r_ptr; the pointer moves
// past the granted port whenever the grant is consumed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;
    int            w_idx;

    // scan from the farthest offset down so the closest requester to r_ptr wins
    always_comb begin
        o_gnt  = '0;
        w_next = r_ptr;
        w_idx  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = (int'(r_ptr) + i) % N;
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
                w_next       = PW'((w_idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr <= '0;
        else if (i_en) r_ptr <= w_next;
    end

endmodule

// File: rtl/pifo_calendar_cmd_arbiter.sv
// pifo_calendar_cmd_arbiter: merges per-port inserts and egress pops into one
// calendar command per cycle, tracks occupancy and opens CPU quiet windows.
module pifo_calendar_cmd_arbiter
    import pifo_calendar_pkg::*;
#(
    parameter int NUM_IN_PORTS       = 4,
    parameter int PIFO_CALENDAR_SIZE = 1024,
    parameter int PIFO_COUNT_WIDTH   = 11,
    parameter int PIFO_ROOT_WIDTH    = 32,
    parameter int BUFFER_ADDR_WIDTH  = 12
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_IN_PORTS-1:0]                 s_ins_valid,
    input  logic [NUM_IN_PORTS*PIFO_ROOT_WIDTH-1:0] s_ins_data,
    output logic [NUM_IN_PORTS-1:0]                 s_ins_ready,
    input  logic                                    s_pop_valid,
    output logic                                    s_pop_ready,
    output logic [BUFFER_ADDR_WIDTH-1:0]            m_pop_addr,
    output logic                                    m_pop_addr_valid,
    output logic                                    m_pop_empty_hit,
    output logic [PIFO_ROOT_WIDTH-1:0]              cal_pifo_info,
    output logic                                    cal_insert_en,
    output logic                                    cal_pop_en,
    input  logic [BUFFER_ADDR_WIDTH-1:0]            cal_head_addr,
    input  logic                                    cal_head_valid,
    input  logic                                    quiesce_req,
    output logic                                    quiesce_ack,
    output logic [PIFO_COUNT_WIDTH-1:0]             occupancy,
    output logic                                    calendar_full,
    output logic                                    calendar_empty
);

    localparam logic [PIFO_COUNT_WIDTH-1:0] C_SIZE = PIFO_COUNT_WIDTH'(PIFO_CALENDAR_SIZE);

    arb_state_t                   r_state;
    arb_state_t                   w_state_next;
    logic                         w_grant_ok;
    logic [PIFO_COUNT_WIDTH-1:0]  r_occ;
    logic                         r_last_was_pop;
    logic                         r_ins_en;
    logic                         r_pop_en;
    logic [PIFO_ROOT_WIDTH-1:0]   r_info;
    logic                         r_resp_pend;
    logic [BUFFER_ADDR_WIDTH-1:0] r_head_addr;
    logic                         r_head_valid;
    logic [NUM_IN_PORTS-1:0]      w_gnt;
    logic [PIFO_ROOT_WIDTH-1:0]   w_ins_data;
    logic                         w_ins_elig;
    logic                         w_pop_elig;
    logic                         w_pick_pop;
    logic                         w_pick_ins;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= st_run;
        else r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = (r_state == st_run)   ? (quiesce_req ? st_drain : st_run) :
                       (r_state == st_drain) ? st_hold :
                                               (quiesce_req ? st_hold : st_run);
    end

    always_comb begin
        w_grant_ok  = (r_state == st_run) && !quiesce_req;
        quiesce_ack = (r_state == st_hold) && quiesce_req;
    end

    rr_arbiter #(.N(NUM_IN_PORTS)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .i_req (s_ins_valid),
        .i_en  (w_pick_ins),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_ins_data = '0;
        for (int k = 0; k < NUM_IN_PORTS; k++)
            w_ins_data = w_gnt[k] ? s_ins_data[k*PIFO_ROOT_WIDTH +: PIFO_ROOT_WIDTH] : w_ins_data;
    end

    // when both sides compete, serve whichever was not served last
    always_comb begin
        w_ins_elig  = w_grant_ok && (|s_ins_valid) && (r_occ < C_SIZE);
        w_pop_elig  = w_grant_ok && s_pop_valid && (r_occ != '0);
        w_pick_pop  = w_pop_elig && (!w_ins_elig || !r_last_was_pop);
        w_pick_ins  = w_ins_elig && !w_pick_pop;
        s_pop_ready = w_pick_pop;
        s_ins_ready = w_pick_ins ? w_gnt : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ          <= '0;
            r_last_was_pop <= 1'b0;
            r_ins_en       <= 1'b0;
            r_pop_en       <= 1'b0;
            r_info         <= '0;
            r_resp_pend    <= 1'b0;
            r_head_addr    <= '0;
            r_head_valid   <= 1'b0;
        end else begin
            r_occ          <= w_pick_ins ? r_occ + 1'b1 : w_pick_pop ? r_occ - 1'b1 : r_occ;
            r_last_was_pop <= (w_ins_elig && w_pop_elig) ? w_pick_pop : r_last_was_pop;
            r_ins_en       <= w_pick_ins;
            r_pop_en       <= w_pick_pop;
            r_info         <= w_pick_ins ? w_ins_data : r_info;
            r_resp_pend    <= r_pop_en;
            r_head_addr    <= r_pop_en ? cal_head_addr : r_head_addr;
            r_head_valid   <= r_pop_en ? cal_head_valid : r_head_valid;
        end
    end

    always_comb begin
        cal_insert_en    = r_ins_en;
        cal_pop_en       = r_pop_en;
        cal_pifo_info    = r_info;
        m_pop_addr       = r_head_addr;
        m_pop_addr_valid = r_resp_pend && r_head_valid;
        m_pop_empty_hit  = r_resp_pend && !r_head_valid;
        occupancy        = r_occ;
        calendar_full    = (r_occ == C_SIZE);
        calendar_empty   = (r_occ == '0);
    end

endmodule

// File: tb/tb_pifo_calendar_cmd_arbiter.sv
// tb_pifo_calendar_cmd_arbiter: directed stimulus pushes expected grants,
// calendar commands and pop responses; a negedge monitor pops and compares.
module tb_pifo_calendar_cmd_arbiter;

    localparam int NP = 4;
    localparam int W  = 32;
    localparam int AW = 12;
    localparam int CW = 4;

    typedef struct packed {
        logic        ins;
        logic        pop;
        logic [31:0] info;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     s_ins_valid;
    logic [NP*W-1:0]   s_ins_data;
    logic [NP-1:0]     s_ins_ready;
    logic              s_pop_valid;
    logic              s_pop_ready;
    logic [AW-1:0]     m_pop_addr;
    logic              m_pop_addr_valid;
    logic              m_pop_empty_hit;
    logic [W-1:0]      cal_pifo_info;
    logic              cal_insert_en;
    logic              cal_pop_en;
    logic [AW-1:0]     cal_head_addr;
    logic              cal_head_valid;
    logic              quiesce_req;
    logic              quiesce_ack;
    logic [CW-1:0]     occupancy;
    logic              calendar_full;
    logic              calendar_empty;

    int checks = 0;
    int errors = 0;
    logic [4:0]  q_gnt[$];
    cmd_t        q_cmd[$];
    logic [12:0] q_resp[$];
    logic [AW-1:0] n_pops = '0;

    always #5 clk = ~clk;

    pifo_calendar_cmd_arbiter #(
        .NUM_IN_PORTS       (NP),
        .PIFO_CALENDAR_SIZE (8),
        .PIFO_COUNT_WIDTH   (CW),
        .PIFO_ROOT_WIDTH    (W),
        .BUFFER_ADDR_WIDTH  (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_ins_valid      (s_ins_valid),
        .s_ins_data       (s_ins_data),
        .s_ins_ready      (s_ins_ready),
        .s_pop_valid      (s_pop_valid),
        .s_pop_ready      (s_pop_ready),
        .m_pop_addr       (m_pop_addr),
        .m_pop_addr_valid (m_pop_addr_valid),
        .m_pop_empty_hit  (m_pop_empty_hit),
        .cal_pifo_info    (cal_pifo_info),
        .cal_insert_en    (cal_insert_en),
        .cal_pop_en       (cal_pop_en),
        .cal_head_addr    (cal_head_addr),
        .cal_head_valid   (cal_head_valid),
        .quiesce_req      (quiesce_req),
        .quiesce_ack      (quiesce_ack),
        .occupancy        (occupancy),
        .calendar_full    (calendar_full),
        .calendar_empty   (calendar_empty)
    );

    // calendar head model: the n-th popped head is 0x120+n, every 4th one invalid
    always @(posedge clk) if (cal_pop_en) n_pops <= n_pops + 1'b1;
    assign cal_head_addr  = 12'h120 + n_pops;
    assign cal_head_valid = (n_pops[1:0] != 2'd3);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s unexpected output %h", name, got);
    endtask

    function automatic logic [31:0] data_of(input int k);
        return 32'h8000_0010 + 32'(k);
    endfunction

    task automatic set_data();
        for (int k = 0; k < NP; k++) s_ins_data[k*W +: W] = data_of(k);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ins(input int k, input logic [31:0] d);
        q_gnt.push_back(5'(1 << k));
        q_cmd.push_back('{ins: 1'b1, pop: 1'b0, info: d});
    endtask

    task automatic push_pop(input logic [11:0] addr, input logic v);
        q_gnt.push_back(5'b10000);
        q_cmd.push_back('{ins: 1'b0, pop: 1'b1, info: 32'h0});
        q_resp.push_back({v, addr});
    endtask

    always @(negedge clk) begin
        cmd_t        ec;
        logic [4:0]  eg;
        logic [12:0] er;
        if (s_pop_ready || (|s_ins_ready)) begin
            if (q_gnt.size() == 0) unexpected("grant", 64'({s_pop_ready, s_ins_ready}));
            else begin
                eg = q_gnt.pop_front();
                check("grant", 64'({s_pop_ready, s_ins_ready}), 64'(eg));
            end
        end
        if (cal_insert_en || cal_pop_en) begin
            if (q_cmd.size() == 0) unexpected("cal_cmd", 64'({cal_insert_en, cal_pop_en, cal_pifo_info}));
            else begin
                ec = q_cmd.pop_front();
                check("cal_cmd", 64'({cal_insert_en, cal_pop_en, cal_insert_en ? cal_pifo_info : 32'h0}),
                      64'({ec.ins, ec.pop, ec.ins ? ec.info : 32'h0}));
            end
        end
        if (m_pop_addr_valid || m_pop_empty_hit) begin
            if (q_resp.size() == 0) unexpected("pop_resp", 64'({m_pop_addr_valid, m_pop_empty_hit, m_pop_addr}));
            else begin
                er = q_resp.pop_front();
                check("pop_resp", 64'({m_pop_addr_valid, m_pop_empty_hit, m_pop_addr_valid ? m_pop_addr : 12'h0}),
                      64'({er[12], !er[12], er[12] ? er[11:0] : 12'h0}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_ins_valid = '0;
        s_pop_valid = 1'b0;
        quiesce_req = 1'b0;
        set_data();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_empty", 64'(calendar_empty), 64'd1);
        check("rst_full", 64'(calendar_full), 64'd0);
        check("rst_ack", 64'(quiesce_ack), 64'd0);
        check("rst_cal", 64'({cal_insert_en, cal_pop_en, cal_pifo_info}), 64'd0);
        check("rst_resp", 64'({m_pop_addr_valid, m_pop_empty_hit, m_pop_addr}), 64'd0);
        tick();
        rst = 1'b0;

        // single insert on port 2
        tick();
        s_ins_data[2*W +: W] = 32'h8000_0ABC;
        s_ins_valid = 4'b0100;
        push_ins(2, 32'h8000_0ABC);
        tick();
        s_ins_valid = '0;
        set_data();
        @(negedge clk);
        check("p1_occupancy", 64'(occupancy), 64'd1);
        check("p1_empty", 64'(calendar_empty), 64'd0);

        // reset, then all ports busy until the calendar fills
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("p2_rst_empty", 64'(calendar_empty), 64'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push_ins(i % 4, data_of(i % 4));
        tick();
        s_ins_valid = 4'hF;
        repeat (8) tick();
        @(negedge clk);
        check("p2_full", 64'(calendar_full), 64'd1);
        check("p2_ins_ready_blocked", 64'(s_ins_ready), 64'd0);
        check("p2_occupancy", 64'(occupancy), 64'd8);
        tick();
        s_ins_valid = '0;

        // pops alone from 8 down to 3
        push_pop(12'h120, 1'b1);
        push_pop(12'h121, 1'b1);
        push_pop(12'h122, 1'b1);
        push_pop(12'h123, 1'b0);
        push_pop(12'h124, 1'b1);
        s_pop_valid = 1'b1;
        repeat (5) tick();
        s_pop_valid = 1'b0;
        @(negedge clk);
        check("p3_occupancy", 64'(occupancy), 64'd3);
        check("p3_full", 64'(calendar_full), 64'd0);
        tick();

        // pop and insert compete: alternate, starting with pop
        push_pop(12'h125, 1'b1);
        push_ins(1, data_of(1));
        push_pop(12'h126, 1'b1);
        push_ins(3, data_of(3));
        push_pop(12'h127, 1'b0);
        push_ins(1, data_of(1));
        s_pop_valid = 1'b1;
        s_ins_valid = 4'b1010;
        repeat (6) tick();
        s_pop_valid = 1'b0;
        s_ins_valid = '0;
        @(negedge clk);
        check("p3b_occupancy", 64'(occupancy), 64'd3);
        tick();

        // drain to empty with pop still requested
        push_pop(12'h128, 1'b1);
        push_pop(12'h129, 1'b1);
        push_pop(12'h12A, 1'b1);
        s_pop_valid = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("p4_pop_ready_blocked", 64'(s_pop_ready), 64'd0);
        check("p4_empty", 64'(calendar_empty), 64'd1);
        check("p4_occupancy", 64'(occupancy), 64'd0);
        tick();
        s_pop_valid = 1'b0;

        // quiet window during an insert burst
        push_ins(2, data_of(2));
        push_ins(3, data_of(3));
        push_ins(0, data_of(0));
        push_ins(1, data_of(1));
        s_ins_valid = 4'hF;
        tick();
        tick();
        quiesce_req = 1'b1;
        @(negedge clk);
        check("q_no_grant", 64'({s_pop_ready, s_ins_ready}), 64'd0);
        check("q_ack_c0", 64'(quiesce_ack), 64'd0);
        tick();
        @(negedge clk);
        check("q_ack_c1", 64'(quiesce_ack), 64'd0);
        tick();
        @(negedge clk);
        check("q_ack_c2", 64'(quiesce_ack), 64'd1);
        tick();
        tick();
        @(negedge clk);
        check("q_ack_c4", 64'(quiesce_ack), 64'd1);
        tick();
        quiesce_req = 1'b0;
        @(negedge clk);
        check("q_ack_release", 64'(quiesce_ack), 64'd0);
        check("q_release_no_grant", 64'({s_pop_ready, s_ins_ready}), 64'd0);
        tick();
        tick();
        tick();
        s_ins_valid = '0;
        @(negedge clk);
        check("q_occupancy", 64'(occupancy), 64'd4);
        tick();

        // reset one cycle after a pop transfer discards its response
        q_gnt.push_back(5'b10000);
        s_pop_valid = 1'b1;
        tick();
        s_pop_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("r_occupancy", 64'(occupancy), 64'd0);
        check("r_empty", 64'(calendar_empty), 64'd1);
        tick();
        rst = 1'b0;
        s_ins_valid = 4'hF;
        push_ins(0, data_of(0));
        tick();
        s_ins_valid = '0;
        repeat (4) tick();
        @(negedge clk);
        check("r_occupancy_after", 64'(occupancy), 64'd1);
        check("gnt_queue_drained", 64'(q_gnt.size()), 64'd0);
        check("cmd_queue_drained", 64'(q_cmd.size()), 64'd0);
        check("resp_queue_drained", 64'(q_resp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
